// File: rtl/lite_poll_pkg.sv
// Shared encodings for the AXI4-Lite DMA status poller: FSM states,
// DMASR bit positions and the OKAY response code.
package lite_poll_pkg;

    typedef enum logic [6:0] {
        ST_IDLE = 7'b000_0001,
        ST_SEL  = 7'b000_0010,
        ST_ADDR = 7'b000_0100,
        ST_DATA = 7'b000_1000,
        ST_EVAL = 7'b001_0000,
        ST_GAP  = 7'b010_0000,
        ST_DONE = 7'b100_0000
    } lite_poll_state_e;

    localparam int STS_HALTED = 0;
    localparam int STS_IDLE   = 1;
    localparam int STS_ERR_LO = 4;
    localparam int STS_ERR_HI = 6;
    localparam int STS_IOC    = 12;

    localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/lite_poll_ch_sel.sv
// Find-first-set over the pending-channel mask, skipping bits below i_lb.
module lite_poll_ch_sel #(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = 1,
    parameter int LB_W   = 2
) (
    input  logic [NUM_CH-1:0] i_pend,
    input  logic [LB_W-1:0]   i_lb,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_vld
);

    // Scan from the top so the last hit wins, leaving the lowest eligible bit.
    always_comb begin
        o_idx = '0;
        o_vld = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (i_pend[i] && (i >= int'(i_lb))) begin
                o_idx = IDX_W'(i);
                o_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lite_status_poller.sv
// Round-robin AXI4-Lite poller of per-channel DMA status registers with poll gap and watchdog.
// Optional feature macro POLL_IOC_EN: IOC_Irq (bit 12) also settles a channel and is reported on ch_ioc.
module lite_status_poller
    import lite_poll_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int NUM_CH    = 2,
    parameter int BASE_OFS  = 'h04,
    parameter int CH_STRIDE = 'h30,
    parameter int POLL_GAP  = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic [ADDR_W-1:0] m_axi_lite_araddr,
    output logic              m_axi_lite_arvalid,
    input  logic              m_axi_lite_arready,
    input  logic [DATA_W-1:0] m_axi_lite_rdata,
    input  logic [1:0]        m_axi_lite_rresp,
    input  logic              m_axi_lite_rvalid,
    output logic              m_axi_lite_rready,
    output logic              busy,
    output logic              done,
    output logic [NUM_CH-1:0] ch_idle,
    output logic [NUM_CH-1:0] ch_halted,
    output logic [NUM_CH-1:0] ch_err,
`ifdef POLL_IOC_EN
    output logic [NUM_CH-1:0] ch_ioc,
`endif
    output logic              timeout,
    output lite_poll_state_e  dbg_state
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int LB_W  = $clog2(NUM_CH + 1);
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam int GAP_W = $clog2(POLL_GAP + 1);

    lite_poll_state_e  r_state, w_state_nxt;
    logic [NUM_CH-1:0] r_pend, w_pend_eval;
    logic [LB_W-1:0]   r_lb;
    logic [IDX_W-1:0]  r_idx, w_sel_idx;
    logic              w_sel_vld;
    logic [ADDR_W-1:0] r_araddr;
    logic              r_st_halted, r_st_idle, r_st_err;
    logic [NUM_CH-1:0] r_ch_idle, r_ch_halted, r_ch_err;
    logic [WD_W-1:0]   r_wd_cnt;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic              r_timeout;
    logic              w_start_acc, w_ar_hs, w_r_hs, w_settled, w_above;
    logic              w_unused_rdata;
`ifdef POLL_IOC_EN
    logic              r_st_ioc;
    logic [NUM_CH-1:0] r_ch_ioc;
`endif

    assign w_unused_rdata = ^m_axi_lite_rdata;
    assign w_start_acc    = (r_state == ST_IDLE) && start;
    // A beat transfers on a rising edge where valid and ready are both high;
    // arvalid/araddr stay fixed until arready, and rready is only raised after the AR beat.
    assign w_ar_hs        = (r_state == ST_ADDR) && m_axi_lite_arready;
    assign w_r_hs         = (r_state == ST_DATA) && m_axi_lite_rvalid;

`ifdef POLL_IOC_EN
    assign w_settled = r_st_halted | r_st_idle | r_st_err | r_st_ioc;
`else
    assign w_settled = r_st_halted | r_st_idle | r_st_err;
`endif

    lite_poll_ch_sel #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W),
        .LB_W   (LB_W)
    ) u_ch_sel (
        .i_pend (r_pend),
        .i_lb   (r_lb),
        .o_idx  (w_sel_idx),
        .o_vld  (w_sel_vld)
    );

    always_comb begin
        w_pend_eval = r_pend;
        if (w_settled) w_pend_eval[r_idx] = 1'b0;
        w_above = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_pend_eval[i] && (i > int'(r_idx))) w_above = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt        = r_state;
        m_axi_lite_arvalid = 1'b0;
        m_axi_lite_rready  = 1'b0;
        busy               = 1'b1;
        done               = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) w_state_nxt = (ch_mask == '0) ? ST_DONE : ST_SEL;
            end
            ST_SEL:  w_state_nxt = w_sel_vld ? ST_ADDR : ST_DONE;
            ST_ADDR: begin
                m_axi_lite_arvalid = 1'b1;
                if (m_axi_lite_arready) w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                m_axi_lite_rready = 1'b1;
                if (m_axi_lite_rvalid) w_state_nxt = ST_EVAL;
            end
            // Fully settled goes back through SEL, which then finds nothing and finishes.
            ST_EVAL: w_state_nxt = (w_above || (w_pend_eval == '0)) ? ST_SEL : ST_GAP;
            ST_GAP:  if (r_gap_cnt == GAP_W'(POLL_GAP - 1)) w_state_nxt = ST_SEL;
            ST_DONE: begin
                busy        = 1'b0;
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                busy        = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend      <= '0;
            r_lb        <= '0;
            r_idx       <= '0;
            r_araddr    <= '0;
            r_st_halted <= 1'b0;
            r_st_idle   <= 1'b0;
            r_st_err    <= 1'b0;
            r_ch_idle   <= '0;
            r_ch_halted <= '0;
            r_ch_err    <= '0;
`ifdef POLL_IOC_EN
            r_st_ioc    <= 1'b0;
            r_ch_ioc    <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: if (start) begin
                    r_pend      <= ch_mask;
                    r_lb        <= '0;
                    r_ch_idle   <= '0;
                    r_ch_halted <= '0;
                    r_ch_err    <= '0;
`ifdef POLL_IOC_EN
                    r_ch_ioc    <= '0;
`endif
                end
                ST_SEL: if (w_sel_vld) begin
                    r_idx    <= w_sel_idx;
                    r_araddr <= ADDR_W'(BASE_OFS + int'(w_sel_idx) * CH_STRIDE);
                end
                ST_DATA: if (m_axi_lite_rvalid) begin
                    r_st_halted <= m_axi_lite_rdata[STS_HALTED];
                    r_st_idle   <= m_axi_lite_rdata[STS_IDLE];
                    r_st_err    <= (|m_axi_lite_rdata[STS_ERR_HI:STS_ERR_LO]) ||
                                   (m_axi_lite_rresp != RESP_OKAY);
`ifdef POLL_IOC_EN
                    r_st_ioc    <= m_axi_lite_rdata[STS_IOC];
`endif
                end
                ST_EVAL: begin
                    r_ch_halted[r_idx] <= r_st_halted;
                    r_ch_idle[r_idx]   <= r_st_idle;
                    r_ch_err[r_idx]    <= r_st_err;
`ifdef POLL_IOC_EN
                    r_ch_ioc[r_idx]    <= r_st_ioc;
`endif
                    r_pend <= w_pend_eval;
                    r_lb   <= LB_W'(r_idx) + LB_W'(1);
                end
                ST_GAP:  r_lb <= '0;
                default: ;
            endcase
        end
    end

    // Watchdog only reports; the FSM keeps waiting for the slave.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_start_acc) r_timeout <= 1'b0;
            if ((r_state == ST_ADDR) || (r_state == ST_DATA)) begin
                if (w_ar_hs || w_r_hs) begin
                    r_wd_cnt <= '0;
                end else begin
                    if (r_wd_cnt != WD_W'(TIMEOUT)) r_wd_cnt <= r_wd_cnt + WD_W'(1);
                    if (r_wd_cnt == WD_W'(TIMEOUT - 1)) r_timeout <= 1'b1;
                end
            end else begin
                r_wd_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   r_gap_cnt <= '0;
        else if (r_state == ST_GAP) r_gap_cnt <= r_gap_cnt + GAP_W'(1);
        else                       r_gap_cnt <= '0;
    end

    assign m_axi_lite_araddr = r_araddr;
    assign ch_idle           = r_ch_idle;
    assign ch_halted         = r_ch_halted;
    assign ch_err            = r_ch_err;
`ifdef POLL_IOC_EN
    assign ch_ioc            = r_ch_ioc;
`endif
    assign timeout           = r_timeout;
    assign dbg_state         = r_state;

endmodule

// File: tb/tb_lite_status_poller.sv
// Bench for lite_status_poller: AXI4-Lite slave model with an address scoreboard,
// a table of single-round polls and hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_lite_status_poller;
    import lite_poll_pkg::*;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int NUM_CH = 2;

    logic              clk, rst, start;
    logic [NUM_CH-1:0] ch_mask;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid, arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid, rready;
    logic              busy, done, timeout;
    logic [NUM_CH-1:0] ch_idle, ch_halted, ch_err;
`ifdef POLL_IOC_EN
    logic [NUM_CH-1:0] ch_ioc;
`endif
    lite_poll_state_e  dbg_state;

    lite_status_poller dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .ch_mask            (ch_mask),
        .m_axi_lite_araddr  (araddr),
        .m_axi_lite_arvalid (arvalid),
        .m_axi_lite_arready (arready),
        .m_axi_lite_rdata   (rdata),
        .m_axi_lite_rresp   (rresp),
        .m_axi_lite_rvalid  (rvalid),
        .m_axi_lite_rready  (rready),
        .busy               (busy),
        .done               (done),
        .ch_idle            (ch_idle),
        .ch_halted          (ch_halted),
        .ch_err             (ch_err),
`ifdef POLL_IOC_EN
        .ch_ioc             (ch_ioc),
`endif
        .timeout            (timeout),
        .dbg_state          (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: expected read addresses and the responses to hand back, in read order.
    logic [ADDR_W-1:0] exp_q[$];
    logic [31:0]       rd_q[$];
    logic [1:0]        rr_q[$];

    int                ar_delay   = 0;
    int                ar_wait    = 0;
    bit                r_hold     = 0;
    bit                tmo_chk    = 0;
    bit                r_owed     = 0;
    bit                busy_seen  = 0;
    int                n_reads    = 0;
    int                gap_cycles = 0;
    logic              last_arvalid = 1'b0;
    logic              last_rready  = 1'b0;
    logic [ADDR_W-1:0] last_araddr  = '0;

    function automatic logic [ADDR_W-1:0] ch_addr(input int ch);
        return ADDR_W'(32'h04 + ch * 32'h30);
    endfunction

    // Slave model: acts 1ns after each rising edge using the values seen at that edge.
    initial begin
        logic ar_hs, r_hs;
        arready = 1'b0;
        rvalid  = 1'b0;
        rdata   = '0;
        rresp   = 2'b00;
        forever begin
            @(posedge clk);
            #1;
            ar_hs = arready && last_arvalid;
            r_hs  = rvalid && last_rready;
            if (rst) begin
                arready      = 1'b0;
                rvalid       = 1'b0;
                r_owed       = 0;
                ar_wait      = 0;
                last_arvalid = 1'b0;
                last_rready  = 1'b0;
            end else begin
                if (ar_hs) begin
                    n_reads++;
                    if (exp_q.size() == 0) check("ar_unexpected", 32'(last_araddr), 32'h3ff);
                    else                   check("araddr", 32'(last_araddr), 32'(exp_q.pop_front()));
                    arready = 1'b0;
                    ar_wait = 0;
                    r_owed  = 1;
                end else if (last_arvalid) begin
                    check("ar_hold", {arvalid, araddr}, {1'b1, last_araddr});
                end
                if (r_hs) rvalid = 1'b0;
                if (r_owed && !r_hold && !rvalid) begin
                    rdata  = (rd_q.size() != 0) ? rd_q.pop_front() : 32'h1;
                    rresp  = (rr_q.size() != 0) ? rr_q.pop_front() : 2'b00;
                    rvalid = 1'b1;
                    r_owed = 0;
                end
                if (arvalid && !arready) begin
                    if (tmo_chk && ar_wait == 250) check("tmo_early", timeout, 0);
                    if (tmo_chk && ar_wait == 260) check("tmo_set", timeout, 1);
                    if (ar_wait >= ar_delay) arready = 1'b1;
                    else                     ar_wait++;
                end
                if (arvalid || rready) check("ar_r_excl", arvalid && rready, 0);
                if (dbg_state == ST_GAP) gap_cycles++;
                if (busy) busy_seen = 1;
                last_arvalid = arvalid;
                last_rready  = rready;
                last_araddr  = araddr;
            end
        end
    end

    task automatic do_poll(input logic [1:0] mask, input bit stray, input int budget,
                           output int cyc, output bit seen);
        n_reads    = 0;
        gap_cycles = 0;
        busy_seen  = 0;
        cyc        = 0;
        seen       = 0;
        start      = 1'b1;
        ch_mask    = mask;
        while (!seen && cyc < budget) begin
            @(posedge clk);
            #3;
            start = 1'b0;
            cyc++;
            if (stray && cyc == 5) begin
                start   = 1'b1;
                ch_mask = 2'b01;
            end
            if (done) seen = 1;
        end
        start = 1'b0;
        check("done_seen", seen, 1);
        if (seen) begin
            @(posedge clk);
            #3;
            check("done_width", done, 0);
            check("busy_after", busy, 0);
        end
    endtask

    typedef struct {
        logic [1:0]  mask;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  r0;
        logic [1:0]  r1;
        logic [1:0]  e_idle;
        logic [1:0]  e_halted;
        logic [1:0]  e_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int cyc;
        bit seen;
        #400000;
        $display("FAIL global_time_limit: got %0d expected %0d", cyc, 0);
        $fatal(1, "time limit");
    end

    initial begin
        int  cyc;
        bit  seen;
        int  exp_reads;

        //             mask   d0            d1          r0     r1     idle   halted err
        vecs[0] = '{2'b11, 32'h0000_0001, 32'h0000_0002, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00};
        vecs[1] = '{2'b01, 32'h0000_0070, 32'h0000_0000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
        vecs[2] = '{2'b10, 32'h0000_0000, 32'h0000_0003, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00};
        vecs[3] = '{2'b11, 32'h0000_0000, 32'h0000_0010, 2'b10, 2'b00, 2'b00, 2'b00, 2'b11};
        vecs[4] = '{2'b01, 32'h0000_0042, 32'h0000_0000, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01};
        vecs[5] = '{2'b11, 32'hffff_ffff, 32'h0000_0002, 2'b00, 2'b11, 2'b11, 2'b01, 2'b11};

        rst     = 1'b1;
        start   = 1'b0;
        ch_mask = '0;
        repeat (3) @(posedge clk);
        #3;
        check("rst_araddr", araddr, 0);
        check("rst_arvalid", arvalid, 0);
        check("rst_rready", rready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_flags", {ch_idle, ch_halted, ch_err, timeout}, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #3;
        check("idle_outputs", {arvalid, rready, busy, done}, 0);

        // Single-round polls where every selected channel settles on its first read.
        for (int v = 0; v < 6; v++) begin
            exp_reads = 0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (vecs[v].mask[ch]) begin
                    exp_q.push_back(ch_addr(ch));
                    rd_q.push_back(ch == 0 ? vecs[v].d0 : vecs[v].d1);
                    rr_q.push_back(ch == 0 ? vecs[v].r0 : vecs[v].r1);
                    exp_reads++;
                end
            end
            do_poll(vecs[v].mask, 0, 100, cyc, seen);
            check($sformatf("v%0d_idle", v), ch_idle, vecs[v].e_idle);
            check($sformatf("v%0d_halted", v), ch_halted, vecs[v].e_halted);
            check($sformatf("v%0d_err", v), ch_err, vecs[v].e_err);
            check($sformatf("v%0d_reads", v), n_reads, exp_reads);
            check($sformatf("v%0d_gap", v), gap_cycles, 0);
            check($sformatf("v%0d_sb_empty", v), exp_q.size(), 0);
        end

        // Channel 1 unsettled three times: three full gaps, stray start ignored.
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(ch_addr(1));
            rd_q.push_back(k == 3 ? 32'h2 : 32'h0);
            rr_q.push_back(2'b00);
        end
        do_poll(2'b10, 1, 300, cyc, seen);
        check("gap_cycles", gap_cycles, 48);
        check("gap_reads", n_reads, 4);
        check("gap_idle", ch_idle, 2'b10);
        check("gap_halted", ch_halted, 2'b00);
        check("gap_sb_empty", exp_q.size(), 0);

        // Mixed round: ch0 settles at once, ch1 needs a second round.
        exp_q.push_back(ch_addr(0)); rd_q.push_back(32'h2); rr_q.push_back(2'b00);
        exp_q.push_back(ch_addr(1)); rd_q.push_back(32'h0); rr_q.push_back(2'b00);
        exp_q.push_back(ch_addr(1)); rd_q.push_back(32'h1); rr_q.push_back(2'b00);
        do_poll(2'b11, 0, 200, cyc, seen);
        check("mix_reads", n_reads, 3);
        check("mix_gap", gap_cycles, 16);
        check("mix_idle", ch_idle, 2'b01);
        check("mix_halted", ch_halted, 2'b10);

        // Slow arready: watchdog flags, poll still completes, flag clears on next start.
        ar_delay = 300;
        tmo_chk  = 1;
        exp_q.push_back(ch_addr(0)); rd_q.push_back(32'h2); rr_q.push_back(2'b00);
        do_poll(2'b01, 0, 400, cyc, seen);
        check("tmo_sticky", timeout, 1);
        check("tmo_idle", ch_idle, 2'b01);
        check("tmo_reads", n_reads, 1);
        ar_delay = 0;
        tmo_chk  = 0;
        exp_q.push_back(ch_addr(0)); rd_q.push_back(32'h1); rr_q.push_back(2'b00);
        do_poll(2'b01, 0, 100, cyc, seen);
        check("tmo_cleared", timeout, 0);
        check("tmo2_halted", ch_halted, 2'b01);

        // Reset while waiting in DATA, then a fresh poll from channel 0.
        r_hold = 1;
        exp_q.push_back(ch_addr(0)); rd_q.push_back(32'h1); rr_q.push_back(2'b00);
        start   = 1'b1;
        ch_mask = 2'b11;
        seen    = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk);
            #3;
            start = 1'b0;
            if (rready) seen = 1;
        end
        start = 1'b0;
        check("rst_reach_data", seen, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_arvalid", arvalid, 0);
        check("rst_mid_rready", rready, 0);
        check("rst_mid_busy", busy, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        exp_q.delete();
        rd_q.delete();
        rr_q.delete();
        r_hold = 0;
        check("rst_mid_araddr", araddr, 0);
        exp_q.push_back(ch_addr(0)); rd_q.push_back(32'h1); rr_q.push_back(2'b00);
        exp_q.push_back(ch_addr(1)); rd_q.push_back(32'h1); rr_q.push_back(2'b00);
        @(posedge clk);
        #3;
        do_poll(2'b11, 0, 100, cyc, seen);
        check("after_rst_reads", n_reads, 2);
        check("after_rst_halted", ch_halted, 2'b11);

        // Empty mask: done the very next cycle, no reads, never busy.
        do_poll(2'b00, 0, 10, cyc, seen);
        check("mask0_latency", cyc, 1);
        check("mask0_reads", n_reads, 0);
        check("mask0_busy", busy_seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lite_status_poller.md
Name: lite_status_poller

Overview:
Polls the status register of up to NUM_CH DMA channels over AXI4-Lite, e.g. MM2S DMASR at 0x04 and S2MM DMASR at 0x34.
- Per-channel idle, halted and error results; a completion pulse once every selected channel has settled.
- Programmable gap between poll rounds and a handshake watchdog.
- Sits beside the DMA write/config controllers and replaces single-channel, single-register status readers.

Parameters:
ADDR_W, 10, AXI-Lite address width
DATA_W, 32, read data width (>=32)
NUM_CH, 2, number of channels polled (1..8)
BASE_OFS, 'h04, status register offset of channel 0
CH_STRIDE, 'h30, address step between channels
POLL_GAP, 16, idle cycles between poll rounds (>=1)
TIMEOUT, 255, cycles allowed per AR or R handshake before flagging

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
start  in  1  one-cycle request; ignored while busy
ch_mask  in  NUM_CH  channels to poll; sampled on accepted start
m_axi_lite_araddr  out  ADDR_W  read address
m_axi_lite_arvalid  out  1  read address valid
m_axi_lite_arready  in  1  read address ready
m_axi_lite_rdata  in  DATA_W  read data
m_axi_lite_rresp  in  2  read response
m_axi_lite_rvalid  in  1  read data valid
m_axi_lite_rready  out  1  read data ready
busy  out  1  poll operation in progress
done  out  1  one-cycle pulse when all masked channels have settled
ch_idle  out  NUM_CH  channel reported Idle (bit1)
ch_halted  out  NUM_CH  channel reported Halted (bit0)
ch_err  out  NUM_CH  channel reported error (bits 6:4) or rresp != OKAY
timeout  out  1  sticky; a handshake exceeded TIMEOUT

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0, including araddr.
- Accepted start with ch_mask==0: done pulses the next cycle, busy never asserts.
- Accepted start with ch_mask!=0:
  - latch mask into pend[]; clear ch_idle, ch_halted, ch_err and timeout; busy=1.
- States:
  - IDLE.
  - SEL: pick the lowest set pend[] bit via find-first-set. If none, go to DONE; otherwise go to ADDR.
  - ADDR: arvalid=1, araddr=BASE_OFS+idx*CH_STRIDE. Both are held stable until arready. Move to DATA the cycle after the handshake.
  - DATA: rready=1 until rvalid. Capture rdata/rresp on the handshake, then go to EVAL.
  - EVAL: one cycle.
    - Set ch_halted[idx]=rdata[0], ch_idle[idx]=rdata[1].
    - Set ch_err[idx]=|rdata[6:4] or rresp!=2'b00.
    - If any of the three is set, clear pend[idx] (settled).
    - Go to SEL if an unvisited pend bit above idx remains this round; else go to GAP.
  - GAP: count POLL_GAP cycles, then go to SEL starting from the lowest pend bit.
  - DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- arvalid and rready are never both high; one outstanding read at a time.
- arvalid is never withdrawn before arready, per AXI.
- Watchdog:
  - An internal counter runs in ADDR and DATA and resets on each handshake.
  - Reaching TIMEOUT sets timeout; the state machine keeps waiting (report only).
  - timeout clears only on the next accepted start.
- start while busy has no effect. The mask is held for the whole operation.
- ch_* outputs hold their values after DONE until the next accepted start.
- Address arithmetic is truncated to ADDR_W.
- Reset mid-transaction drops arvalid/rready immediately; no recovery of the in-flight read.

Optional Feature:
POLL_IOC_EN
- Defined: rdata[12] (IOC_Irq) also counts as settled. Adds output ch_ioc[NUM_CH], captured in EVAL like the other flags.
- Undefined: bit 12 is ignored and the ch_ioc port is absent.

Decomposition:
- Package lite_poll_pkg holds:
  - state encoding (one-hot, 7 states);
  - status bit positions: HALTED=0, IDLE=1, ERR_LO=4, ERR_HI=6, IOC=12;
  - RESP_OKAY=2'b00.
- One sub-module, lite_poll_ch_sel: combinational find-first-set over pend[] with a lower-bound index. It returns idx and a valid flag.

Test Plan:
- NUM_CH=2, mask=2'b11; slave returns 0x0001 at 0x04 and 0x0002 at 0x34 → two reads in order 0x04 then 0x34; ch_halted=01, ch_idle=10; done pulses 1 cycle; no GAP entered.
- mask=2'b10; ch1 returns 0x0000 three times, then 0x0002 → only address 0x34 issued; three GAP periods of 16 cycles each; done after the fourth read.
- arready delayed 300 cycles → araddr/arvalid held stable throughout; timeout=1 at cycle 255; poll completes normally; timeout clears on the next start.
- rresp=2'b10 with rdata=0 → ch_err=1; channel settled; done pulses.
- Reset asserted during DATA → arvalid=rready=busy=0 immediately; a new start reissues from 0x04.
- mask=0 → done pulses the next cycle; no AR traffic; busy stays 0.
